simon_game_rounds: RTL and testbench
====================================

Name: simon_game_rounds

Overview:
- Parametrised, progressive-round Simon game core for the board top level.
- Each round appends one pseudo-random LED index to a stored sequence, plays the whole sequence back on the LEDs, then checks the player's switch toggles one step at a time.
- The game ends in WIN when MAX_LEN steps are repeated correctly, or in LOSE on a wrong toggle or an input timeout.
- Drives LEDs, a level counter and a result code; 7-segment decoding is done outside this block.

Parameters:
- N_LEDS, 8, number of LEDs and switches; must be a power of 2, ≥2. IDX_W = $clog2(N_LEDS).
- MAX_LEN, 16, number of steps in a full game (rounds 1..MAX_LEN); 2..255.
- ON_TICKS, 25_000_000, cycles an LED stays lit per playback step.
- GAP_TICKS, 12_500_000, dark cycles after each playback step.
- DEBOUNCE_TICKS, 1_000_000, cycles a synchronised switch change must stay stable to be accepted.
- TIMEOUT_TICKS, 250_000_000, maximum cycles allowed per input step.
- LFSR_SEED, 16'hACE1, nonzero reset value of the internal 16-bit LFSR.

Ports:
- clk, in, 1, system clock (50 MHz on the board).
- rst_n, in, 1, asynchronous, active-low reset.
- start, in, 1, level-sampled; a high start in IDLE, WIN or LOSE begins a new game.
- sw, in, N_LEDS, player switches (asynchronous to clk).
- led, out, N_LEDS, one-hot during playback, otherwise all zero.
- level, out, 8, current round number: 0 in IDLE, 1..MAX_LEN while playing, final value held in WIN/LOSE.
- input_en, out, 1, high while player input is accepted.
- result, out, 2, game result: 00 idle/playing, 01 WIN, 10 LOSE.

Behaviour:
- Reset values: led=0, level=0, input_en=0, result=00, state IDLE, LFSR=LFSR_SEED, all counters 0, sequence memory 0. Reset takes effect immediately at any point, including mid-playback or mid-input.
- LFSR:
  - 16-bit Fibonacci, taps 16,14,13,11; advances every cycle in every state.
  - New element = LFSR[IDX_W-1:0], sampled in the ADD cycle.
- Sequence memory: MAX_LEN entries of IDX_W bits. Entries persist across rounds; only entry level-1 is written each round.
- Switch path:
  - 2-flop synchroniser, then the debouncer compares against sw_ref.
  - A difference held for DEBOUNCE_TICKS consecutive cycles produces a one-cycle event; at the same edge sw_ref takes the synchronised value and the debounce count clears.
  - Any reversion clears the count.
  - Debouncer runs in all states; events outside INPUT are discarded, but sw_ref still updates.
  - Event index = lowest set bit of (sw_ref XOR new value). A multi-switch change counts as one entry.
- FSM (one transition per cycle unless stated):
  - IDLE: when start=1 → ADD. Clear level to 0 on exit.
  - ADD (1 cycle): level++, write the element to entry level-1 (new value), clear the step pointer → SHOW_ON.
  - SHOW_ON: led = one-hot(entry[ptr]) for ON_TICKS cycles → SHOW_GAP.
  - SHOW_GAP: led=0 for GAP_TICKS cycles. Then ptr++; if ptr == level → INPUT with ptr=0 and timeout counter cleared; else → SHOW_ON.
  - INPUT: input_en=1.
    - Event with index == entry[ptr]: if ptr == level-1, go to WIN when level == MAX_LEN, else go to ADD. Otherwise ptr++ and clear the timeout counter.
    - Event with index != entry[ptr] → LOSE.
    - Timeout counter reaching TIMEOUT_TICKS-1 with no event → LOSE. An event arriving in that same cycle takes priority over the timeout.
  - WIN: result=01, led=0, hold. start=1 → IDLE-equivalent restart: level=0, go directly to ADD next cycle.
  - LOSE: result=10, led=0, hold. start=1 → restart as in WIN.
- Timing: first LED lights 2 cycles after start is sampled in IDLE (IDLE→ADD→SHOW_ON). Playback of round k lasts k*(ON_TICKS+GAP_TICKS) cycles. input_en rises in the cycle after the final gap ends.
- Restart: the LFSR is not reseeded on restart, so a new game gives a new sequence.
- start held high in IDLE/WIN/LOSE triggers one game; it is ignored in all other states.
- All counters are sized with $clog2 of their terminal value; level is 8 bits and never wraps, because MAX_LEN ≤ 255.

Test Plan:
Bench parameters: N_LEDS=8, MAX_LEN=3, ON=4, GAP=2, DEBOUNCE=3, TIMEOUT=50.
- Reset mid-SHOW_ON (assert rst_n=0 at an arbitrary cycle) → led=0, level=0, result=00, input_en=0 asynchronously; after release the block stays in IDLE until start.
- start pulse → first one-hot LED appears 2 cycles later and lasts 4 cycles, then 2 dark cycles, then input_en=1, level=1. The LED index equals LFSR_SEED-derived bits [2:0] predicted by a bench LFSR model.
- Replay the correct toggles for rounds 1..3, each held ≥5 cycles → rounds play 1, 2, 3 LEDs, earlier entries unchanged; after the final correct toggle result=01, level=3.
- In round 2, toggle a wrong switch → result=10, level=2, led=0. A toggle shorter than 3 cycles (glitch) → no event, state unchanged.
- In INPUT, apply no toggles → result=10 exactly 50 cycles after input_en rose. Toggle two switches in the same cycle where the lower index is correct → accepted as a single correct step.
- From WIN, raise start → level returns to 1, new playback begins 1 cycle later, and its first element differs from the prior game's per the LFSR model.

Source files
------------

// File: rtl/simon_game_rounds.sv
// Progressive-round Simon game core.
// Each round appends one LFSR-derived LED index to the stored sequence,
// plays the whole sequence back on the LEDs, then checks the player's
// debounced switch toggles one step at a time. Outputs are registered
// copies of the state decode, so they trail the state register by one cycle.
module simon_game_rounds #(
  parameter int          N_LEDS         = 8,
  parameter int          MAX_LEN        = 16,
  parameter int          ON_TICKS       = 25_000_000,
  parameter int          GAP_TICKS      = 12_500_000,
  parameter int          DEBOUNCE_TICKS = 1_000_000,
  parameter int          TIMEOUT_TICKS  = 250_000_000,
  parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic [N_LEDS-1:0] i_sw,
  output logic [N_LEDS-1:0] o_led,
  output logic [7:0]        o_level,
  output logic              o_input_en,
  output logic [1:0]        o_result
);

  // Counter width for a terminal count n (at least one bit).
  function automatic int f_cnt_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  localparam int IDX_W    = $clog2(N_LEDS);
  localparam int TICK_MAX = (ON_TICKS > GAP_TICKS) ? ON_TICKS : GAP_TICKS;
  localparam int TICK_W   = f_cnt_w(TICK_MAX);
  localparam int DB_W     = f_cnt_w(DEBOUNCE_TICKS);
  localparam int TO_W     = f_cnt_w(TIMEOUT_TICKS);
  localparam int PTR_W    = f_cnt_w(MAX_LEN);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ADD      = 3'd1,
    S_SHOW_ON  = 3'd2,
    S_SHOW_GAP = 3'd3,
    S_INPUT    = 3'd4,
    S_WIN      = 3'd5,
    S_LOSE     = 3'd6
  } state_t;

  // Index of the lowest set bit; a multi-switch change resolves to one entry.
  function automatic logic [IDX_W-1:0] f_lowest_idx(input logic [N_LEDS-1:0] v);
    logic [IDX_W-1:0] idx;
    idx = {IDX_W{1'b0}};
    for (int i = N_LEDS - 1; i >= 0; i--) begin
      if (v[i]) begin
        idx = IDX_W'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

  // One-hot LED pattern for an index.
  function automatic logic [N_LEDS-1:0] f_onehot(input logic [IDX_W-1:0] idx);
    logic [N_LEDS-1:0] v;
    v      = {N_LEDS{1'b0}};
    v[idx] = 1'b1;
    return v;
  endfunction

  state_t              r_state;
  state_t              w_state_nxt;
  logic [15:0]         r_lfsr;
  logic [N_LEDS-1:0]   r_sw_s1;
  logic [N_LEDS-1:0]   r_sw_s2;
  logic [N_LEDS-1:0]   r_sw_ref;
  logic [DB_W-1:0]     r_db_cnt;
  logic                r_ev;
  logic [IDX_W-1:0]    r_ev_idx;
  logic [7:0]          r_level;
  logic [PTR_W-1:0]    r_ptr;
  logic [TICK_W-1:0]   r_tick;
  logic [TO_W-1:0]     r_to_cnt;
  logic [IDX_W-1:0]    r_mem [MAX_LEN];
  logic [N_LEDS-1:0]   r_led;
  logic                r_input_en;
  logic [1:0]          r_result;

  logic [N_LEDS-1:0]   w_sw_diff;
  logic [IDX_W-1:0]    w_elem;
  logic                w_on_done;
  logic                w_gap_done;
  logic                w_last_show;
  logic                w_last_step;
  logic                w_ev_ok;
  logic                w_to_done;
  logic [N_LEDS-1:0]   w_led_nxt;
  logic                w_input_en_nxt;
  logic [1:0]          w_result_nxt;

  assign w_sw_diff   = r_sw_s2 ^ r_sw_ref;
  assign w_elem      = r_lfsr[IDX_W-1:0];
  assign w_on_done   = (r_tick == TICK_W'(ON_TICKS - 1));
  assign w_gap_done  = (r_tick == TICK_W'(GAP_TICKS - 1));
  assign w_last_show = ((8'(r_ptr) + 8'd1) == r_level);
  assign w_last_step = (8'(r_ptr) == (r_level - 8'd1));
  assign w_ev_ok     = (r_ev_idx == r_mem[r_ptr]);
  assign w_to_done   = (r_to_cnt == TO_W'(TIMEOUT_TICKS - 1));

  assign o_led      = r_led;
  assign o_level    = r_level;
  assign o_input_en = r_input_en;
  assign o_result   = r_result;

  // Free-running Fibonacci LFSR (taps 16,14,13,11), never reseeded on restart.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_lfsr <= LFSR_SEED;
    end else begin
      r_lfsr <= {r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5], r_lfsr[15:1]};
    end
  end

  // Two-flop synchroniser for the asynchronous switches.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sw_s1 <= {N_LEDS{1'b0}};
      r_sw_s2 <= {N_LEDS{1'b0}};
    end else begin
      r_sw_s1 <= i_sw;
      r_sw_s2 <= r_sw_s1;
    end
  end

  // Debouncer: a change stable for DEBOUNCE_TICKS cycles yields a one-cycle event.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sw_ref <= {N_LEDS{1'b0}};
      r_db_cnt <= {DB_W{1'b0}};
      r_ev     <= 1'b0;
      r_ev_idx <= {IDX_W{1'b0}};
    end else begin
      r_ev <= 1'b0;
      if (w_sw_diff != {N_LEDS{1'b0}}) begin
        if (r_db_cnt == DB_W'(DEBOUNCE_TICKS - 1)) begin
          r_ev     <= 1'b1;
          r_ev_idx <= f_lowest_idx(w_sw_diff);
          r_sw_ref <= r_sw_s2;
          r_db_cnt <= {DB_W{1'b0}};
        end else begin
          r_db_cnt <= r_db_cnt + DB_W'(1);
        end
      end else begin
        r_db_cnt <= {DB_W{1'b0}};
      end
    end
  end

  // FSM state register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state logic; an input event outranks the timeout in the same cycle.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE, S_WIN, S_LOSE: begin
        if (i_start) w_state_nxt = S_ADD;
        else         w_state_nxt = r_state;
      end
      S_ADD: w_state_nxt = S_SHOW_ON;
      S_SHOW_ON: begin
        if (w_on_done) w_state_nxt = S_SHOW_GAP;
        else           w_state_nxt = S_SHOW_ON;
      end
      S_SHOW_GAP: begin
        if (w_gap_done) w_state_nxt = w_last_show ? S_INPUT : S_SHOW_ON;
        else            w_state_nxt = S_SHOW_GAP;
      end
      S_INPUT: begin
        if (r_ev) begin
          if (!w_ev_ok)         w_state_nxt = S_LOSE;
          else if (w_last_step) w_state_nxt = (r_level == 8'(MAX_LEN)) ? S_WIN : S_ADD;
          else                  w_state_nxt = S_INPUT;
        end else if (w_to_done) begin
          w_state_nxt = S_LOSE;
        end else begin
          w_state_nxt = S_INPUT;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Round datapath: level, step pointer, playback/timeout counters, sequence memory.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_level  <= 8'd0;
      r_ptr    <= {PTR_W{1'b0}};
      r_tick   <= {TICK_W{1'b0}};
      r_to_cnt <= {TO_W{1'b0}};
      for (int i = 0; i < MAX_LEN; i++) begin
        r_mem[i] <= {IDX_W{1'b0}};
      end
    end else begin
      case (r_state)
        S_IDLE, S_WIN, S_LOSE: begin
          if (i_start) r_level <= 8'd0;
          else         r_level <= r_level;
        end
        S_ADD: begin
          r_level                  <= r_level + 8'd1;
          r_mem[r_level[PTR_W-1:0]] <= w_elem;
          r_ptr                    <= {PTR_W{1'b0}};
          r_tick                   <= {TICK_W{1'b0}};
        end
        S_SHOW_ON: begin
          if (w_on_done) r_tick <= {TICK_W{1'b0}};
          else           r_tick <= r_tick + TICK_W'(1);
        end
        S_SHOW_GAP: begin
          if (w_gap_done) begin
            r_tick <= {TICK_W{1'b0}};
            if (w_last_show) begin
              r_ptr    <= {PTR_W{1'b0}};
              r_to_cnt <= {TO_W{1'b0}};
            end else begin
              r_ptr <= r_ptr + PTR_W'(1);
            end
          end else begin
            r_tick <= r_tick + TICK_W'(1);
          end
        end
        S_INPUT: begin
          if (r_ev) begin
            if (w_ev_ok && !w_last_step) begin
              r_ptr    <= r_ptr + PTR_W'(1);
              r_to_cnt <= {TO_W{1'b0}};
            end else begin
              r_ptr <= r_ptr;
            end
          end else begin
            r_to_cnt <= r_to_cnt + TO_W'(1);
          end
        end
        default: r_level <= r_level;
      endcase
    end
  end

  // FSM output decode from the current state.
  always_comb begin
    w_led_nxt      = {N_LEDS{1'b0}};
    w_input_en_nxt = 1'b0;
    w_result_nxt   = 2'b00;
    case (r_state)
      S_SHOW_ON: w_led_nxt      = f_onehot(r_mem[r_ptr]);
      S_INPUT:   w_input_en_nxt = 1'b1;
      S_WIN:     w_result_nxt   = 2'b01;
      S_LOSE:    w_result_nxt   = 2'b10;
      default:   w_result_nxt   = 2'b00;
    endcase
  end

  // Output registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_led      <= {N_LEDS{1'b0}};
      r_input_en <= 1'b0;
      r_result   <= 2'b00;
    end else begin
      r_led      <= w_led_nxt;
      r_input_en <= w_input_en_nxt;
      r_result   <= w_result_nxt;
    end
  end

endmodule

// File: tb/tb_simon_game_rounds.sv
// Self-checking bench for simon_game_rounds with small timing parameters.
module tb_simon_game_rounds;

  localparam int ML = 3;
  localparam int ON = 4;
  localparam int TO = 50;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] sw = 8'd0;
  logic [7:0] t_led;
  logic [7:0] t_level;
  logic       t_en;
  logic [1:0] t_res;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  simon_game_rounds #(
    .N_LEDS(8), .MAX_LEN(ML), .ON_TICKS(ON), .GAP_TICKS(2),
    .DEBOUNCE_TICKS(3), .TIMEOUT_TICKS(TO), .LFSR_SEED(16'hACE1)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_sw(sw),
    .o_led(t_led), .o_level(t_level), .o_input_en(t_en), .o_result(t_res)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp_v);
    end
  endtask

  // Reference LFSR; m_prev holds the value seen before the latest clock edge.
  logic [15:0] m_lfsr, m_prev;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_lfsr <= 16'hACE1;
      m_prev <= 16'hACE1;
    end else begin
      m_prev <= m_lfsr;
      m_lfsr <= {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
    end
  end

  // Scoreboard: each new level pushes the round's expected playback; each LED pulse pops one.
  logic [2:0] exp_seq [ML];
  int         exp_q [$];
  logic [7:0] prev_level, prev_led;
  logic       prev_en;
  logic [1:0] prev_res;
  int         cyc = 0, run_len = 0, en_rise_cyc = 0, res_rise_cyc = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_level <= 8'd0;
      prev_led   <= 8'd0;
      prev_en    <= 1'b0;
      prev_res   <= 2'b00;
      run_len    <= 0;
      exp_q.delete();
    end else begin
      cyc <= cyc + 1;
      if (t_level != prev_level && t_level != 8'd0 && t_level <= 8'(ML)) begin
        for (int i = 0; i < int'(t_level) - 1; i++) exp_q.push_back(int'(exp_seq[i]));
        exp_q.push_back(int'(m_prev[2:0]));
        exp_seq[int'(t_level) - 1] <= m_prev[2:0];
      end
      if (t_led != 8'd0 && prev_led == 8'd0) begin
        if (exp_q.size() == 0) check("led_unexpected", 32'(t_led), 32'd0);
        else                   check("led_index", 32'(t_led), 32'(8'd1 << exp_q.pop_front()));
      end
      if (t_led == 8'd0 && prev_led != 8'd0) check("led_on_len", run_len, ON);
      run_len <= (t_led != 8'd0) ? run_len + 1 : 0;
      if (t_en && !prev_en) en_rise_cyc <= cyc;
      if (t_res != 2'b00 && prev_res == 2'b00) res_rise_cyc <= cyc;
      prev_level <= t_level;
      prev_led   <= t_led;
      prev_en    <= t_en;
      prev_res   <= t_res;
    end
  end

  typedef enum int {A_START, A_PLAY, A_GLITCH, A_WRONG, A_DOUBLE, A_TIMEOUT} act_t;
  typedef struct {
    act_t       act;
    logic [7:0] exp_level;
    logic [1:0] exp_result;
    logic       exp_en;
  } vec_t;

  vec_t vecs [11];
  int   m_level = 0;

  task automatic flip(input logic [7:0] mask, input int hold);
    sw = sw ^ mask;
    repeat (hold) @(negedge clk);
  endtask

  task automatic wait_en_rise(input string nm);
    int k = 0;
    while (t_en !== 1'b0 && k < 100) begin @(negedge clk); k++; end
    while (t_en !== 1'b1 && k < 300) begin @(negedge clk); k++; end
    check(nm, 32'(t_en), 32'd1);
  endtask

  task automatic wait_result(input string nm);
    int k = 0;
    while (t_res === 2'b00 && k < 150) begin @(negedge clk); k++; end
    #1;
    check(nm, 32'(t_res != 2'b00), 32'd1);
  endtask

  // Start pulse with a cycle-accurate look at round-1 playback timing.
  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int j = 1; j <= 8; j++) begin
      @(negedge clk);
      if (j == 1) begin
        check("start_level1", 32'(t_level), 32'd1);
        check("start_led_dark", 32'(t_led), 32'd0);
        check("start_result", 32'(t_res), 32'd0);
      end else if (j <= 5) begin
        check("start_led_on", 32'(t_led != 8'd0), 32'd1);
      end else begin
        check("start_gap_dark", 32'(t_led), 32'd0);
        check("start_en", 32'(t_en), (j == 8) ? 32'd1 : 32'd0);
      end
    end
    m_level = 1;
  endtask

  initial begin
    vecs[0]  = '{A_START,   8'd1, 2'b00, 1'b1};
    vecs[1]  = '{A_PLAY,    8'd2, 2'b00, 1'b1};
    vecs[2]  = '{A_PLAY,    8'd3, 2'b00, 1'b1};
    vecs[3]  = '{A_PLAY,    8'd3, 2'b01, 1'b0};
    vecs[4]  = '{A_START,   8'd1, 2'b00, 1'b1};
    vecs[5]  = '{A_PLAY,    8'd2, 2'b00, 1'b1};
    vecs[6]  = '{A_GLITCH,  8'd2, 2'b00, 1'b1};
    vecs[7]  = '{A_WRONG,   8'd2, 2'b10, 1'b0};
    vecs[8]  = '{A_START,   8'd1, 2'b00, 1'b1};
    vecs[9]  = '{A_DOUBLE,  8'd2, 2'b00, 1'b1};
    vecs[10] = '{A_TIMEOUT, 8'd2, 2'b10, 1'b0};

    // Reset state, then idle with no start.
    repeat (2) @(negedge clk);
    check("rst_led", 32'(t_led), 32'd0);
    check("rst_level", 32'(t_level), 32'd0);
    check("rst_result", 32'(t_res), 32'd0);
    check("rst_en", 32'(t_en), 32'd0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("idle_level", 32'(t_level), 32'd0);

    // Asynchronous reset in the middle of playback.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 10 && t_led == 8'd0; k++) @(negedge clk);
    check("midshow_led_seen", 32'(t_led != 8'd0), 32'd1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_led", 32'(t_led), 32'd0);
    check("async_rst_level", 32'(t_level), 32'd0);
    check("async_rst_result", 32'(t_res), 32'd0);
    check("async_rst_en", 32'(t_en), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("post_rst_led", 32'(t_led), 32'd0);
    check("post_rst_level", 32'(t_level), 32'd0);

    // Table-driven game scenarios.
    for (int v = 0; v < 11; v++) begin
      case (vecs[v].act)
        A_START: do_start();
        A_PLAY: begin
          for (int i = 0; i < m_level; i++) flip(8'd1 << exp_seq[i], 6);
          if (m_level == ML) wait_result($sformatf("v%0d_win_seen", v));
          else               wait_en_rise($sformatf("v%0d_en_rise", v));
          m_level++;
        end
        A_GLITCH: begin
          flip(8'd1 << ((int'(exp_seq[0]) + 1) % 8), 2);
          flip(8'd1 << ((int'(exp_seq[0]) + 1) % 8), 10);
        end
        A_WRONG: begin
          flip(8'd1 << ((int'(exp_seq[0]) + 1) % 8), 1);
          wait_result($sformatf("v%0d_lose_seen", v));
        end
        A_DOUBLE: begin
          if (exp_seq[0] < 3'd7) flip((8'd3 << exp_seq[0]), 6);
          else                   flip(8'h80, 6);
          wait_en_rise($sformatf("v%0d_en_rise", v));
          m_level = 2;
        end
        A_TIMEOUT: begin
          wait_result($sformatf("v%0d_timeout_seen", v));
          check("timeout_cycles", 32'(res_rise_cyc - en_rise_cyc), 32'(TO));
        end
        default: check("bad_vector", 32'd1, 32'(v));
      endcase
      check($sformatf("v%0d_level", v), 32'(t_level), 32'(vecs[v].exp_level));
      check($sformatf("v%0d_result", v), 32'(t_res), 32'(vecs[v].exp_result));
      check($sformatf("v%0d_input_en", v), 32'(t_en), 32'(vecs[v].exp_en));
      check($sformatf("v%0d_led", v), 32'(t_led), 32'd0);
    end

    repeat (4) @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
